store_buffer: RTL and testbench

- Committed-store buffer between the memory stage and the data cache.
- Accepts store requests from the memory stage, holds each entry until write-back commits or an exception flush discards it, then drains committed entries in order to the dcache over a req/addr_ok/data_ok handshake.
- Tells younger loads to stall when they hit a buffered word.

---
 rtl/store_buffer_pkg.sv | 37 +++
 rtl/store_buffer_drain_ctrl.sv | 97 +++++++++
 rtl/store_buffer.sv | 176 +++++++++++++++++
 tb/tb_store_buffer.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// ---------------------------------------------------------------------------
// store_buffer_pkg
//   Shared definitions for the committed-store buffer:
//   - SB_STRB_W           : byte-enable width of a store
//   - drain_state_e       : drain FSM encodings (IDLE=0, REQ=1, WAIT=2)
//   - sb_entry_width()    : width of one packed buffer entry
//   - sb_entry_*_lsb()    : field offsets inside a packed entry
//
//   Packed entry / drain bus layout, MSB to LSB:
//     { addr[ADDR_W-1:0], wdata[DATA_W-1:0], wstrb[3:0], uncache }
// ---------------------------------------------------------------------------
package store_buffer_pkg;

    localparam int SB_STRB_W = 4;

    typedef enum logic [1:0] {
        DRAIN_IDLE = 2'd0,
        DRAIN_REQ  = 2'd1,
        DRAIN_WAIT = 2'd2
    } drain_state_e;

    // Entry width: address + data + byte enables + uncached attribute.
    function automatic int sb_entry_width(input int addr_w, input int data_w);
        return addr_w + data_w + SB_STRB_W + 1;
    endfunction

    // Bit offset of the data field inside a packed entry.
    function automatic int sb_entry_data_lsb();
        return SB_STRB_W + 1;
    endfunction

    // Bit offset of the address field inside a packed entry.
    function automatic int sb_entry_addr_lsb(input int data_w);
        return data_w + SB_STRB_W + 1;
    endfunction

endpackage

// File: rtl/store_buffer_drain_ctrl.sv
// ---------------------------------------------------------------------------
// store_buffer_drain_ctrl
//   Drains committed store-buffer entries, oldest first, to the dcache.
//   Owns the head pointer and produces the pop pulse for the entry storage.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   i_ncommitted      : committed-but-not-popped entry count (registered)
//   i_commit          : a commit is being applied this cycle
//   i_cache_addr_ok   : dcache accepted the request
//   i_cache_data_ok   : dcache completed the write
//   o_cache_req       : drain request to the dcache
//   o_head_ptr        : index of the entry being drained
//   o_pop             : head entry retires at the next clock edge
//   o_state           : current FSM state (debug)
//
// dcache handshake: o_cache_req is held high with stable fields until a cycle
// in which i_cache_addr_ok is high; that cycle is the request transfer. The
// write then completes on the first later cycle with i_cache_data_ok high,
// which is when the head entry is popped. data_ok never coincides with
// addr_ok for the same request.
// ---------------------------------------------------------------------------
module store_buffer_drain_ctrl
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] i_ncommitted,
    input  logic             i_commit,
    input  logic             i_cache_addr_ok,
    input  logic             i_cache_data_ok,
    output logic             o_cache_req,
    output logic [PTR_W-1:0] o_head_ptr,
    output logic             o_pop,
    output drain_state_e     o_state
);

    drain_state_e     r_state;
    drain_state_e     w_state_next;
    logic [PTR_W-1:0] r_head;
    logic             w_pop;
    logic [CNT_W-1:0] w_remaining;

    // Committed entries still waiting once the head pops, counting a commit
    // that lands in the same cycle so back-to-back drains need no idle gap.
    assign w_remaining = i_ncommitted - CNT_W'(1) + CNT_W'(i_commit);

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            DRAIN_IDLE: begin
                // A commit this cycle is enough to start: request shows up
                // the cycle after the commit.
                if ((i_ncommitted != '0) || i_commit) begin
                    w_state_next = DRAIN_REQ;
                end
            end
            DRAIN_REQ: begin
                if (i_cache_addr_ok) begin
                    w_state_next = DRAIN_WAIT;
                end
            end
            DRAIN_WAIT: begin
                if (i_cache_data_ok) begin
                    w_pop        = 1'b1;
                    w_state_next = (w_remaining != '0) ? DRAIN_REQ : DRAIN_IDLE;
                end
            end
            default: begin
                w_state_next = DRAIN_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= DRAIN_IDLE;
            r_head  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
        end
    end

    assign o_cache_req = (r_state == DRAIN_REQ);
    assign o_head_ptr  = r_head;
    assign o_pop       = w_pop;
    assign o_state     = r_state;

endmodule

// File: rtl/store_buffer.sv
// ---------------------------------------------------------------------------
// store_buffer
//   Committed-store buffer between the memory stage and the dcache. Stores
//   are pushed speculatively, retired in order by commit_i, discarded by
//   flush_i when still uncommitted, and drained in order to the dcache.
//   Loads that hit a buffered word are told to stall.
//
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   push_valid_i / push_ready_o : store push handshake (ready = ~full_o)
//   push_addr_i, push_wdata_i,
//   push_wstrb_i, push_uncache_i: store fields
//   commit_i                    : retire oldest uncommitted store
//   flush_i                     : discard all uncommitted stores
//   ld_valid_i, ld_addr_i       : younger load lookup
//   ld_hit_o                    : load word matches a live entry
//   cache_req_o, cache_addr_o,
//   cache_wdata_o, cache_wstrb_o,
//   cache_uncache_o             : drain request to the dcache
//   cache_addr_ok_i,
//   cache_data_ok_i             : dcache request/completion strobes
//   empty_o, full_o             : occupancy flags
//
// Push handshake: a store transfers on a cycle where push_valid_i and
// push_ready_o are both high and flush_i is low. push_ready_o depends only on
// registered occupancy, never on a same-cycle pop.
// ---------------------------------------------------------------------------
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_valid_i,
    output logic              push_ready_o,
    input  logic [ADDR_W-1:0] push_addr_i,
    input  logic [DATA_W-1:0] push_wdata_i,
    input  logic [3:0]        push_wstrb_i,
    input  logic              push_uncache_i,
    input  logic              commit_i,
    input  logic              flush_i,
    input  logic              ld_valid_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    output logic              ld_hit_o,
    output logic              cache_req_o,
    output logic [ADDR_W-1:0] cache_addr_o,
    output logic [DATA_W-1:0] cache_wdata_o,
    output logic [3:0]        cache_wstrb_o,
    output logic              cache_uncache_o,
    input  logic              cache_addr_ok_i,
    input  logic              cache_data_ok_i,
    output logic              empty_o,
    output logic              full_o
);

    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int ENTRY_W  = sb_entry_width(ADDR_W, DATA_W);
    localparam int ADDR_LSB = sb_entry_addr_lsb(DATA_W);
    localparam int DATA_LSB = sb_entry_data_lsb();

    // Entry storage carries no reset: liveness is defined purely by the
    // pointers and count, so stale contents are never observed.
    logic [ENTRY_W-1:0] r_entry [DEPTH];

    logic [PTR_W-1:0]   r_tail;
    logic [PTR_W-1:0]   r_cmt;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   r_ncommitted;

    logic [PTR_W-1:0]   w_head;
    logic               w_pop;
    logic               w_cache_req;
    drain_state_e       w_drain_state;

    logic               w_full;
    logic               w_empty;
    logic [CNT_W-1:0]   w_uncommitted;
    logic               w_do_push;
    logic               w_do_commit;
    logic [PTR_W-1:0]   w_cmt_next;
    logic [CNT_W-1:0]   w_nc_next;
    logic [ENTRY_W-1:0] w_head_entry;
    logic [DEPTH-1:0]   w_live;
    logic [DEPTH-1:0]   w_match;
    logic               w_unused;

    assign w_full        = (r_count == CNT_W'(DEPTH));
    assign w_empty       = (r_count == '0);
    assign w_uncommitted = r_count - r_ncommitted;

    assign w_do_push   = push_valid_i & ~w_full & ~flush_i;
    // A commit with nothing uncommitted is an upstream bug; it is ignored
    // here so the pointers cannot run past the tail.
    assign w_do_commit = commit_i & (w_uncommitted != '0);

    // Ordering within one cycle: commit, then flush, then pop.
    assign w_cmt_next = r_cmt + PTR_W'(w_do_commit);
    assign w_nc_next  = r_ncommitted + CNT_W'(w_do_commit) - CNT_W'(w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tail       <= '0;
            r_cmt        <= '0;
            r_count      <= '0;
            r_ncommitted <= '0;
        end else begin
            r_cmt        <= w_cmt_next;
            r_ncommitted <= w_nc_next;
            if (flush_i) begin
                // Everything past the commit point is discarded; what remains
                // is exactly the committed set (after any pop this cycle).
                r_tail  <= w_cmt_next;
                r_count <= w_nc_next;
            end else begin
                r_tail  <= r_tail + PTR_W'(w_do_push);
                r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_entry[r_tail] <= {push_addr_i, push_wdata_i, push_wstrb_i, push_uncache_i};
        end
    end

    // An entry is live when its distance from the head is below count; this
    // keeps the head entry live until its data_ok pop.
    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        logic [PTR_W-1:0] w_offset;
        assign w_offset   = PTR_W'(g) - w_head;
        assign w_live[g]  = ({1'b0, w_offset} < r_count);
        assign w_match[g] = w_live[g] &
                            (r_entry[g][ENTRY_W-1 -: ADDR_W-2] == ld_addr_i[ADDR_W-1:2]);
    end

    assign ld_hit_o = ld_valid_i & (|w_match);

    store_buffer_drain_ctrl #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .CNT_W (CNT_W)
    ) u_drain_ctrl (
        .clk             (clk),
        .rst             (rst),
        .i_ncommitted    (r_ncommitted),
        .i_commit        (w_do_commit),
        .i_cache_addr_ok (cache_addr_ok_i),
        .i_cache_data_ok (cache_data_ok_i),
        .o_cache_req     (w_cache_req),
        .o_head_ptr      (w_head),
        .o_pop           (w_pop),
        .o_state         (w_drain_state)
    );

    // Drain fields are zero whenever no request is outstanding.
    assign w_head_entry    = r_entry[w_head];
    assign cache_req_o     = w_cache_req;
    assign cache_addr_o    = w_cache_req ? w_head_entry[ADDR_LSB +: ADDR_W] : '0;
    assign cache_wdata_o   = w_cache_req ? w_head_entry[DATA_LSB +: DATA_W] : '0;
    assign cache_wstrb_o   = w_cache_req ? w_head_entry[1 +: SB_STRB_W] : '0;
    assign cache_uncache_o = w_cache_req & w_head_entry[0];

    assign empty_o      = w_empty;
    assign full_o       = w_full;
    assign push_ready_o = ~w_full;

    // Byte offset of the load is irrelevant to a word match; drain state is
    // exported by the controller for observation only.
    assign w_unused = ^{ld_addr_i[1:0], w_drain_state};

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int EW     = ADDR_W + DATA_W + 5;

    // ---------------- clock / reset ----------------
    logic              clk = 1'b0;
    logic              rst = 1'b1;
    always #5 clk = ~clk;

    logic              push_valid_i = 1'b0;
    logic              push_ready_o;
    logic [ADDR_W-1:0] push_addr_i = '0;
    logic [DATA_W-1:0] push_wdata_i = '0;
    logic [3:0]        push_wstrb_i = '0;
    logic              push_uncache_i = 1'b0;
    logic              commit_i = 1'b0;
    logic              flush_i = 1'b0;
    logic              ld_valid_i = 1'b0;
    logic [ADDR_W-1:0] ld_addr_i = '0;
    logic              ld_hit_o;
    logic              cache_req_o;
    logic [ADDR_W-1:0] cache_addr_o;
    logic [DATA_W-1:0] cache_wdata_o;
    logic [3:0]        cache_wstrb_o;
    logic              cache_uncache_o;
    logic              cache_addr_ok_i = 1'b0;
    logic              cache_data_ok_i = 1'b0;
    logic              empty_o;
    logic              full_o;

    store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .push_valid_i    (push_valid_i),
        .push_ready_o    (push_ready_o),
        .push_addr_i     (push_addr_i),
        .push_wdata_i    (push_wdata_i),
        .push_wstrb_i    (push_wstrb_i),
        .push_uncache_i  (push_uncache_i),
        .commit_i        (commit_i),
        .flush_i         (flush_i),
        .ld_valid_i      (ld_valid_i),
        .ld_addr_i       (ld_addr_i),
        .ld_hit_o        (ld_hit_o),
        .cache_req_o     (cache_req_o),
        .cache_addr_o    (cache_addr_o),
        .cache_wdata_o   (cache_wdata_o),
        .cache_wstrb_o   (cache_wstrb_o),
        .cache_uncache_o (cache_uncache_o),
        .cache_addr_ok_i (cache_addr_ok_i),
        .cache_data_ok_i (cache_data_ok_i),
        .empty_o         (empty_o),
        .full_o          (full_o)
    );

    // ---------------- scoreboard / model ----------------
    int n_checks = 0;
    int n_errors = 0;

    logic [EW-1:0] pend_q[$];    // pushed, not committed
    logic [EW-1:0] exp_q[$];     // committed, drain request not yet accepted
    logic [EW-1:0] inflight = '0;
    logic          inflight_v = 1'b0;
    logic          dc_busy = 1'b0;
    int            dc_wait = 0;
    int            req_age = 0;
    int            addr_dly = 1;
    int            data_dly = 1;

    typedef struct {
        logic              vld;
        logic [ADDR_W-1:0] addr;
        logic              exp_hit;
    } hit_vec_t;
    hit_vec_t hit_tab [6];

    function automatic logic [EW-1:0] pk(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                                         input logic [3:0] s, input logic u);
        return {a, d, s, u};
    endfunction

    function automatic int model_cnt();
        return pend_q.size() + exp_q.size() + (inflight_v ? 1 : 0);
    endfunction

    function automatic logic word_eq(input logic [EW-1:0] e, input logic [ADDR_W-1:0] a);
        return e[EW-1 -: ADDR_W-2] == a[ADDR_W-1:2];
    endfunction

    function automatic logic model_hit(input logic vld, input logic [ADDR_W-1:0] a);
        logic h = 1'b0;
        foreach (pend_q[i]) if (word_eq(pend_q[i], a)) h = 1'b1;
        foreach (exp_q[i])  if (word_eq(exp_q[i], a))  h = 1'b1;
        if (inflight_v && word_eq(inflight, a)) h = 1'b1;
        return vld & h;
    endfunction

    task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input logic [3:0] s, input logic u);
        push_valid_i   = 1'b1;
        push_addr_i    = a;
        push_wdata_i   = d;
        push_wstrb_i   = s;
        push_uncache_i = u;
    endtask

    // One clock cycle: dcache responder, per-cycle checks, model update, edge.
    // Called at posedge+1 with this cycle's inputs already applied.
    task automatic cyc();
        logic [EW-1:0] req_bus;
        cache_addr_ok_i = 1'b0;
        cache_data_ok_i = 1'b0;
        if (dc_busy) begin
            if (dc_wait == 0) cache_data_ok_i = 1'b1;
            else dc_wait--;
        end else if (cache_req_o) begin
            if (req_age >= addr_dly) cache_addr_ok_i = 1'b1;
            else req_age++;
        end
        #1;
        chk("empty_o", empty_o, model_cnt() == 0);
        chk("full_o", full_o, model_cnt() == DEPTH);
        chk("push_ready_o", push_ready_o, model_cnt() != DEPTH);
        chk("ld_hit_o", ld_hit_o, model_hit(ld_valid_i, ld_addr_i));
        chk("cache_req_o", cache_req_o, (exp_q.size() != 0) && !dc_busy);
        if (cache_req_o && exp_q.size() != 0) begin
            req_bus = {cache_addr_o, cache_wdata_o, cache_wstrb_o, cache_uncache_o};
            chk("drain_entry", req_bus, exp_q[0]);
        end
        if (cache_addr_ok_i) begin
            inflight   = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
            inflight_v = 1'b1;
            dc_busy    = 1'b1;
            dc_wait    = data_dly;
            req_age    = 0;
        end
        if (commit_i) begin
            assert (pend_q.size() != 0) else $error("bench drove commit with nothing uncommitted");
            if (pend_q.size() != 0) exp_q.push_back(pend_q.pop_front());
        end
        if (flush_i) pend_q.delete();
        else if (push_valid_i && model_cnt() < DEPTH)
            pend_q.push_back(pk(push_addr_i, push_wdata_i, push_wstrb_i, push_uncache_i));
        if (cache_data_ok_i) begin
            inflight_v = 1'b0;
            dc_busy    = 1'b0;
        end
        @(posedge clk);
        #1;
        push_valid_i    = 1'b0;
        commit_i        = 1'b0;
        flush_i         = 1'b0;
        ld_valid_i      = 1'b0;
        cache_addr_ok_i = 1'b0;
        cache_data_ok_i = 1'b0;
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        push_valid_i    = 1'b0;
        commit_i        = 1'b0;
        flush_i         = 1'b0;
        ld_valid_i      = 1'b0;
        cache_addr_ok_i = 1'b0;
        cache_data_ok_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        pend_q.delete();
        exp_q.delete();
        inflight_v = 1'b0;
        dc_busy    = 1'b0;
        dc_wait    = 0;
        req_age    = 0;
    endtask

    task automatic run_until_idle(input int budget, input string name);
        int n = 0;
        while ((model_cnt() != 0 || dc_busy) && n < budget) begin
            cyc();
            n++;
        end
        n_checks++;
        if (n >= budget) begin
            n_errors++;
            $display("FAIL %s: drain unfinished after %0d cycles", name, budget);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"}, cache_req_o, 1'b0);
        chk({tag, "_empty"}, empty_o, 1'b1);
        chk({tag, "_full"}, full_o, 1'b0);
        chk({tag, "_ready"}, push_ready_o, 1'b1);
        chk({tag, "_addr"}, cache_addr_o, '0);
        chk({tag, "_wdata"}, cache_wdata_o, '0);
        chk({tag, "_wstrb"}, cache_wstrb_o, '0);
        chk({tag, "_unc"}, cache_uncache_o, 1'b0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        logic [ADDR_W-1:0] a;

        do_reset();
        ld_valid_i = 1'b1;
        ld_addr_i  = 32'h0000_0000;
        #1;
        chk("rst_ld_hit", ld_hit_o, 1'b0);
        ld_valid_i = 1'b0;
        check_reset_outputs("rst");

        // Single store: request two cycles after push, then addr_ok/data_ok.
        push(32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 1'b0);
        cyc();
        chk("t1_no_req_yet", cache_req_o, 1'b0);
        commit_i = 1'b1;
        cyc();
        chk("t1_req", cache_req_o, 1'b1);
        chk("t1_addr", cache_addr_o, 32'h1000_0004);
        chk("t1_wdata", cache_wdata_o, 32'hDEAD_BEEF);
        chk("t1_wstrb", cache_wstrb_o, 4'hF);
        chk("t1_unc", cache_uncache_o, 1'b0);
        cyc();
        chk("t1_req_held", cache_req_o, 1'b1);
        cyc();                              // addr_ok
        chk("t1_req_drop", cache_req_o, 1'b0);
        chk("t1_not_empty", empty_o, 1'b0);
        cyc();
        cyc();                              // data_ok
        chk("t1_empty", empty_o, 1'b1);

        // Fill: four uncommitted pushes, fifth rejected.
        for (int i = 0; i < DEPTH; i++) begin
            push(32'h3000_0000 + 32'(i * 4), $urandom, 4'($urandom_range(1, 15)), 1'b0);
            cyc();
        end
        chk("t2_full", full_o, 1'b1);
        chk("t2_ready", push_ready_o, 1'b0);
        push(32'h3000_0100, 32'h5555_AAAA, 4'hF, 1'b0);
        cyc();
        chk("t2_still_full", full_o, 1'b1);
        ld_valid_i = 1'b1;
        ld_addr_i  = 32'h3000_0100;
        #1;
        chk("t2_rejected_not_live", ld_hit_o, 1'b0);
        ld_addr_i = 32'h3000_000C;
        #1;
        chk("t2_last_live", ld_hit_o, 1'b1);
        flush_i = 1'b1;
        cyc();
        chk("t2_flushed_empty", empty_o, 1'b1);

        // Flush discard: A,B,C pushed; commit A together with the flush.
        push(32'h4000_0000, 32'hAAAA_0001, 4'h1, 1'b0);
        cyc();
        push(32'h4000_0010, 32'hBBBB_0002, 4'h3, 1'b1);
        cyc();
        push(32'h4000_0020, 32'hCCCC_0003, 4'hC, 1'b0);
        cyc();
        commit_i = 1'b1;
        flush_i  = 1'b1;
        cyc();
        run_until_idle(40, "t3_drain");
        chk("t3_empty", empty_o, 1'b1);

        // Flush during drain: A in WAIT, B uncommitted.
        data_dly = 4;
        push(32'h6000_0000, 32'h0A0A_0A0A, 4'hF, 1'b0);
        cyc();
        push(32'h6000_0004, 32'h0B0B_0B0B, 4'hF, 1'b0);
        commit_i = 1'b1;
        cyc();
        n = 0;
        while (!dc_busy && n < 20) begin
            cyc();
            n++;
        end
        chk("t4_reached_wait", dc_busy, 1'b1);
        flush_i = 1'b1;
        cyc();
        run_until_idle(40, "t4_drain");
        chk("t4_empty", empty_o, 1'b1);
        data_dly = 1;
        push(32'h6000_0008, 32'h0C0C_0C0C, 4'h6, 1'b1);
        cyc();
        commit_i = 1'b1;
        cyc();
        run_until_idle(40, "t4_after");

        // Load hit table against a single buffered word.
        hit_tab[0] = '{1'b1, 32'h2000_0008, 1'b1};
        hit_tab[1] = '{1'b1, 32'h2000_000B, 1'b1};
        hit_tab[2] = '{1'b1, 32'h2000_000C, 1'b0};
        hit_tab[3] = '{1'b0, 32'h2000_0008, 1'b0};
        hit_tab[4] = '{1'b1, 32'h2000_0004, 1'b0};
        hit_tab[5] = '{1'b1, 32'hA000_0008, 1'b0};
        push(32'h2000_0008, 32'h1122_3344, 4'hF, 1'b0);
        cyc();
        for (int i = 0; i < 6; i++) begin
            ld_valid_i = hit_tab[i].vld;
            ld_addr_i  = hit_tab[i].addr;
            #1;
            chk($sformatf("hit_vec%0d", i), ld_hit_o, hit_tab[i].exp_hit);
        end
        ld_valid_i = 1'b0;
        commit_i   = 1'b1;
        cyc();
        run_until_idle(40, "t5_drain");
        ld_valid_i = 1'b1;
        ld_addr_i  = 32'h2000_0008;
        #1;
        chk("t5_hit_after_pop", ld_hit_o, 1'b0);
        ld_valid_i = 1'b0;

        // Wrap: six push-commit-drain rounds with overlapping drains.
        for (int i = 0; i < 6; i++) begin
            a = 32'h5000_0000 + 32'(i * 16) + 32'($urandom_range(0, 3) * 4);
            push(a, $urandom, 4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)));
            cyc();
            if (pend_q.size() != 0) commit_i = 1'b1;
            ld_valid_i = 1'b1;
            ld_addr_i  = a | 32'($urandom_range(0, 3));
            cyc();
            for (int k = 0; k < 3; k++) begin
                ld_valid_i = 1'($urandom_range(0, 1));
                ld_addr_i  = 32'h5000_0000 + 32'($urandom_range(0, 23) * 4);
                cyc();
            end
        end
        run_until_idle(60, "t6_drain");
        chk("t6_empty", empty_o, 1'b1);

        // Reset while a request is pending.
        push(32'h7000_0000, 32'hFEED_F00D, 4'hF, 1'b0);
        cyc();
        commit_i = 1'b1;
        cyc();
        n = 0;
        while (!cache_req_o && n < 10) begin
            cyc();
            n++;
        end
        chk("t7_in_req", cache_req_o, 1'b1);
        do_reset();
        check_reset_outputs("t7");
        push(32'h7000_0010, 32'h0123_4567, 4'h5, 1'b1);
        cyc();
        commit_i = 1'b1;
        cyc();
        run_until_idle(40, "t7_restart");
        chk("t7_final_empty", empty_o, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        n_errors++;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
